// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one character per valid/ready handshake,
// runtime baud divisor, parity mode and one/two stop bits, all outputs registered.
module uart_tx_param #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 ready,
  output logic                 TX,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_d;
  logic [DIV_WIDTH-1:0]   cnt, cnt_d;
  logic [IW-1:0]          bit_idx, bit_d;
  logic                   stop_idx, stop_d;
  logic [DATA_BITS-1:0]   data_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [1:0]             mode_q;
  logic                   stop2_q;
  logic                   load;
  logic                   tx_d, ready_d, busy_d, done_d;
  logic [DIV_WIDTH-1:0]   last_cnt;
  logic                   par_en, par_bit;

  // div=0 behaves as div=1, so the terminal count is 0 in both cases
  assign last_cnt = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);
  assign par_en   = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign par_bit  = (^data_q) ^ (mode_q == 2'b10);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    stop_d  = stop_idx;
    load    = 1'b0;
    done_d  = 1'b0;
    if (state == IDLE) begin
      if (valid) begin
        load    = 1'b1;
        state_d = START;
        cnt_d   = '0;
      end
    end else if (cnt != last_cnt) begin
      cnt_d = cnt + DIV_WIDTH'(1);
    end else begin
      cnt_d = '0;
      case (state)
        START: begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          if (bit_idx == LAST_BIT) begin
            state_d = par_en ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_idx + IW'(1);
          end
        end
        PARITY: begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
        STOP: begin
          if (stop2_q && !stop_idx) begin
            stop_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are derived from the next state so they register in step with it
    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_q   <= '0;
      div_q    <= '0;
      mode_q   <= '0;
      stop2_q  <= 1'b0;
      TX       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      stop_idx <= stop_d;
      if (load) begin
        data_q  <= data_in;
        div_q   <= div;
        mode_q  <= parity_mode;
        stop2_q <= stop2;
      end
      TX    <= tx_d;
      ready <= ready_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: 8-bit and 5-bit instances, directed frames
// with hand-written bit patterns expanded per cycle and checked by negedge monitors.
module tb_uart_tx_param;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        valid8, valid5;
  logic [7:0]  data8;
  logic [4:0]  data5;
  logic [15:0] div8, div5;
  logic [1:0]  pm8, pm5;
  logic        s2_8, s2_5;
  logic        ready8, tx8, busy8, done8;
  logic        ready5, tx5, busy5, done5;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  uart_tx_param #(.DATA_BITS(8), .DIV_WIDTH(16)) dut8 (
    .clk(clk), .RST(RST), .valid(valid8), .data_in(data8), .div(div8),
    .parity_mode(pm8), .stop2(s2_8), .ready(ready8), .TX(tx8), .busy(busy8), .done(done8)
  );

  uart_tx_param #(.DATA_BITS(5), .DIV_WIDTH(16)) dut5 (
    .clk(clk), .RST(RST), .valid(valid5), .data_in(data5), .div(div5),
    .parity_mode(pm5), .stop2(s2_5), .ready(ready5), .TX(tx5), .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input int qsize);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d: got queue size %0d expected other", nm, cyc, qsize);
  endtask

  // Monitors: {TX,ready,busy,done} while a frame or done pulse is visible, idle line otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy8 || done8) begin
        if (q8.size() == 0) unexpected("ch8_unexpected_output", 0);
        else begin
          e8 = q8.pop_front();
          chk("ch8_frame", {28'd0, tx8, ready8, busy8, done8},
              {28'd0, e8.tx, ~e8.busy, e8.busy, e8.done});
        end
      end else chk("ch8_idle", {30'd0, tx8, ready8}, 32'd3);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy5 || done5) begin
        if (q5.size() == 0) unexpected("ch5_unexpected_output", 0);
        else begin
          e5 = q5.pop_front();
          chk("ch5_frame", {28'd0, tx5, ready5, busy5, done5},
              {28'd0, e5.tx, ~e5.busy, e5.busy, e5.done});
        end
      end else chk("ch5_idle", {30'd0, tx5, ready5}, 32'd3);
    end
  end

  // pat lists the frame bits in line order (start bit first) as '0'/'1' characters
  task automatic send(input int ch, input logic [7:0] d, input logic [15:0] dv,
                      input logic [1:0] pm, input logic s2, input string pat,
                      input bit hold, output int k);
    bit got;
    int unsigned dd;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    if (ch == 0) begin
      data8 = d; div8 = dv; pm8 = pm; s2_8 = s2; valid8 = 1'b1;
    end else begin
      data5 = d[4:0]; div5 = dv; pm5 = pm; s2_5 = s2; valid5 = 1'b1;
    end
    for (int n = 0; n < 400; n++) begin
      if ((ch == 0 ? ready8 : ready5) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      unexpected("accept_timeout", (ch == 0) ? q8.size() : q5.size());
      valid8 = 1'b0;
      valid5 = 1'b0;
      k = -1;
    end else begin
      k = cyc + 1;
      @(posedge clk);
      #1;
      dd = (dv == 16'd0) ? 1 : 32'(dv);
      for (int i = 0; i < pat.len(); i++) begin
        for (int unsigned r = 0; r < dd; r++) begin
          e.tx = (pat[i] == 8'h31);
          e.busy = 1'b1;
          e.done = 1'b0;
          if (ch == 0) q8.push_back(e); else q5.push_back(e);
        end
      end
      e.tx = 1'b1;
      e.busy = 1'b0;
      e.done = 1'b1;
      if (ch == 0) q8.push_back(e); else q5.push_back(e);
      if (!hold) begin
        if (ch == 0) valid8 = 1'b0; else valid5 = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input int ch);
    for (int n = 0; n < 3000; n++) begin
      if ((ch == 0 ? q8.size() : q5.size()) == 0) break;
      @(negedge clk);
    end
    if ((ch == 0 ? q8.size() : q5.size()) != 0)
      unexpected("drain_timeout", (ch == 0) ? q8.size() : q5.size());
  endtask

  initial begin
    int k, ka, kb;
    RST = 1'b1;
    valid8 = 1'b1; data8 = 8'hFF; div8 = 16'd1; pm8 = 2'b00; s2_8 = 1'b0;
    valid5 = 1'b1; data5 = 5'h1F; div5 = 16'd1; pm5 = 2'b00; s2_5 = 1'b0;

    // Reset held three edges with valid high: idle outputs, nothing accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_ch8", {28'd0, tx8, ready8, busy8, done8}, 32'hC);
      chk("reset_ch5", {28'd0, tx5, ready5, busy5, done5}, 32'hC);
    end
    RST = 1'b0;
    valid8 = 1'b0;
    valid5 = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("no_accept_after_reset", {30'd0, busy8, busy5}, 32'd0);

    send(0, 8'hA5, 16'd4, 2'b00, 1'b0, "0101001011", 1'b0, k);
    wait_drain(0);
    send(0, 8'h07, 16'd3, 2'b01, 1'b1, "011100000111", 1'b0, k);
    wait_drain(0);
    send(0, 8'h07, 16'd3, 2'b10, 1'b1, "011100000011", 1'b0, k);
    wait_drain(0);
    send(0, 8'h3C, 16'd2, 2'b11, 1'b0, "0001111001", 1'b0, k);
    wait_drain(0);

    send(1, 8'h1F, 16'd0, 2'b00, 1'b0, "0111111", 1'b0, k);
    wait_drain(1);
    send(1, 8'h0B, 16'd1, 2'b01, 1'b1, "011010111", 1'b0, k);
    wait_drain(1);

    // Back-to-back: inputs change mid-frame, second frame one idle cycle after done
    send(0, 8'h96, 16'd2, 2'b01, 1'b0, "00110100101", 1'b1, ka);
    repeat (5) @(posedge clk);
    #1;
    data8 = 8'h41; div8 = 16'd1; pm8 = 2'b10; s2_8 = 1'b1;
    send(0, 8'h41, 16'd1, 2'b10, 1'b1, "010000010111", 1'b0, kb);
    chk("b2b_accept_edge", kb, ka + 23);
    wait_drain(0);

    // Reset during data bit 2 (line low), then a clean frame
    send(0, 8'h5A, 16'd4, 2'b00, 1'b0, "0010110101", 1'b0, k);
    repeat (13) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    @(posedge clk);
    #1;
    q8.delete();
    RST = 1'b0;
    @(negedge clk);
    chk("reset_midframe", {28'd0, tx8, ready8, busy8, done8}, 32'hC);
    repeat (10) @(negedge clk);
    send(0, 8'h5A, 16'd3, 2'b01, 1'b0, "00101101001", 1'b0, k);
    wait_drain(0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the next generation of the fixed 8N1 transmit FSM. It serialises one character per valid/ready handshake onto the `TX` line. Data width is set at build time; baud divisor, parity mode and stop-bit count are set per frame. It sits between a byte or word producer (a FIFO or register file) and the pad-level `TX` line.

## Interface
- `DATA_BITS`, default 8: character width, legal range 5..9.
- `DIV_WIDTH`, default 16: width of the runtime baud divisor.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `valid`  in  1: producer has a character.
- `data_in`  in  DATA_BITS: character to send, transmitted LSB first.
- `div`  in  DIV_WIDTH: bit period in `clk` cycles.
- `parity_mode`  in  2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop2`  in  1: 0 gives one stop bit, 1 gives two.
- `ready`  out  1: block can accept a character.
- `TX`  out  1: serial line. Idle level is 1.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: `valid && ready` sampled high at a rising edge.
  - At that edge, `data_in`, `div`, `parity_mode` and `stop2` are latched into internal registers.
  - Input changes during the frame have no effect.
  - `valid` while `ready`=0 is ignored; there is no queueing.
- Effective bit period: D = `div`, except that `div`=0 is treated as D=1.
- The baud counter is DIV_WIDTH bits wide. It counts from 0 to D-1, then wraps and advances to the next bit. It never overflows.
- Frame sequence, each bit held for D cycles:
  - START: `TX`=0.
  - DATA: DATA_BITS bits, LSB first. A bit index counter selects the latched data bit.
  - PARITY: present only if the latched mode is 01 or 10.
    - Even: parity bit = XOR of the data bits.
    - Odd: parity bit = inverted XOR of the data bits.
  - STOP: one stop bit (`stop2`=0) or two (`stop2`=1), `TX`=1.
- Frame length in bits: N = 1 + DATA_BITS + P + S, with P in {0,1} and S in {1,2}.
- STOP to IDLE: `done`=1 for exactly one cycle, `ready`=1, `busy`=0.
- `TX`, `ready`, `busy` and `done` are all registered outputs. There is no combinational path from any input to any output.
- Outputs by state:
  - `ready`=1 only in IDLE.
  - `busy` = NOT `ready`.
- `TX` is driven only from the state register and the latched data, so there are no glitches.

## Timing
- Reset values, one cycle after `RST` is sampled high: `TX`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset mid-frame:
  - The frame is aborted immediately.
  - `TX` returns to 1 at the next edge.
  - No `done` pulse is produced.
  - `RST` takes priority over a simultaneous `valid`.
- With acceptance at edge k:
  - From edge k: `TX`=0, `ready`=0, `busy`=1.
  - Bit j (j=0 is the start bit) is driven from edge k+j·D through edge k+(j+1)·D.
  - At edge k+N·D: state becomes IDLE, `ready`=1, `busy`=0, `done`=1, `TX`=1.
  - At edge k+N·D+1: `done`=0.
- Back-to-back: with `valid` held high, the next acceptance occurs at edge k+N·D+1 at the earliest. This gives a guaranteed minimum inter-frame gap of one extra idle cycle after the last stop bit.
- D=1: every bit lasts exactly one cycle. There are no skipped or doubled bits.
- Latency from acceptance to the falling start edge on `TX`: 1 cycle.

## Test plan
- Reset: hold `RST` for 3 cycles with `valid`=1 -> `TX`=1, `ready`=1, `busy`=0, `done`=0 throughout. No acceptance occurs.
- Basic 8N1: DATA_BITS=8, `div`=4, `data_in`=0xA5, `parity_mode`=00, `stop2`=0.
  - `TX` = 0×4, then 1,0,1,0,0,1,0,1 each ×4, then 1×4.
  - `done` pulses at acceptance edge + 40.
- Parity and two stop bits: `data_in`=0x07, `div`=3.
  - Even mode: parity bit = 1.
  - Odd mode: parity bit = 0.
  - `stop2`=1: stop high for 6 cycles.
  - `done` at +36 (12 bits × 3).
- Width and div edges: DATA_BITS=5, `div`=0, `data_in`=0x1F -> each bit lasts 1 cycle, frame is 7 cycles, `done` at +7.
- Back-to-back with input changes:
  - Hold `valid`=1 and change `data_in`/`div` mid-frame -> the current frame is unchanged.
  - The second frame is accepted exactly at +N·D+1 using the new values.
- Reset mid-frame: assert `RST` in the 3rd data bit -> `TX`=1 next cycle, no `done`, `ready`=1. A new frame afterwards transmits correctly.
